// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared sizes and FSM state encoding for the DMA burst packer.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int BURST_WORDS = 16;
    localparam int RING_WORDS  = 32;
    localparam int PTR_W       = $clog2(RING_WORDS);
    localparam int OCC_W       = PTR_W + 1;
    localparam int BEAT_W      = $clog2(BURST_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dma_burst_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_packer_if
// Description : Byte-stream input and 16-bit FIFO write-port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_burst_packer_if #(
    parameter int CNT_W = 24
);
    logic [7:0]       din;
    logic             dv;
    logic             flush;
    logic             room;
    logic             we;
    logic [15:0]      di;
    logic             busy;
    logic             frame_done;
    logic             overflow;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output din, dv, flush, room,
        input  we, di, busy, frame_done, overflow, word_cnt
    );

    modport slave (
        input  din, dv, flush, room,
        output we, di, busy, frame_done, overflow, word_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dma_pack_ring.sv
`default_nettype none
// ============================================================================
// Module      : dma_pack_ring
// Description : 32x16 word ring with occupancy count; writes drop when full.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_pack_ring
    import dma_pkg::*;
(
    input  logic             clk,
    input  logic             xrst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [15:0]      i_wr_data,
    input  logic             i_rd_en,
    output logic [15:0]      o_rd_data,
    output logic [OCC_W-1:0] o_occ,
    output logic             o_wr_ok,
    output logic             o_overflow
);

    logic [15:0]      r_mem [RING_WORDS];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_overflow;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full = (r_occ == OCC_W'(RING_WORDS));
    assign w_wr   = i_wr_en & ~w_full & ~i_clr;
    assign w_rd   = i_rd_en & (r_occ != '0) & ~i_clr;

    // Storage needs no reset: stale words are never read past the pointers.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else if (i_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_data  = r_mem[r_rptr];
    assign o_occ      = r_occ;
    assign o_wr_ok    = w_wr;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/dma_burst_packer.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_packer
// Description : Packs bytes into 16-bit words and releases them to the DMA
//               FIFO only as whole 16-word bursts, padding at frame end.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_burst_packer
    import dma_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 24
) (
    input  logic               clk,
    input  logic               xrst,
    input  logic               en,
    dma_burst_packer_if.slave  bus
);

    logic [7:0]       r_held;
    logic             r_held_vld;
    state_t           r_state;
    logic [BEAT_W-1:0] r_beat;
    logic             r_pend;
    logic [OCC_W-1:0] r_pad_left;
    logic             r_we;
    logic [15:0]      r_di;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic             w_wr_en;
    logic [15:0]      w_wr_data;
    logic             w_rd_en;
    logic [15:0]      w_rd_data;
    logic [OCC_W-1:0] w_occ;
    logic             w_wr_ok;
    logic             w_overflow;
    logic             w_emit;

    // A flush closes the pairing phase so next-frame bytes never pair with
    // this frame's trailing odd byte.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = {bus.din, r_held};
        if (bus.dv) begin
            if (r_held_vld) begin
                w_wr_en = 1'b1;
            end else if (bus.flush) begin
                w_wr_en   = 1'b1;
                w_wr_data = {PAD_BYTE, bus.din};
            end
        end else if (bus.flush && r_held_vld) begin
            w_wr_en   = 1'b1;
            w_wr_data = {PAD_BYTE, r_held};
        end
    end

    assign w_rd_en = (r_state == SEND) || ((r_state == PAD) && (r_pad_left != '0));
    assign w_emit  = (r_pad_left != '0) || (r_cnt[BEAT_W-1:0] != '0);

    dma_pack_ring u_ring (
        .clk        (clk),
        .xrst       (xrst),
        .i_clr      (~en),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (w_rd_en),
        .o_rd_data  (w_rd_data),
        .o_occ      (w_occ),
        .o_wr_ok    (w_wr_ok),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_held     <= '0;
            r_held_vld <= 1'b0;
            r_state    <= IDLE;
            r_beat     <= '0;
            r_pend     <= 1'b0;
            r_pad_left <= '0;
            r_we       <= 1'b0;
            r_di       <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else if (!en) begin
            r_held     <= '0;
            r_held_vld <= 1'b0;
            r_state    <= IDLE;
            r_beat     <= '0;
            r_pend     <= 1'b0;
            r_pad_left <= '0;
            r_we       <= 1'b0;
            r_di       <= '0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (r_done) begin
                r_cnt <= '0;
            end

            if (bus.dv && !r_held_vld && !bus.flush) begin
                r_held     <= bus.din;
                r_held_vld <= 1'b1;
            end else if (w_wr_en) begin
                r_held_vld <= 1'b0;
            end

            // r_pad_left tracks how many ring words still belong to the
            // flushed frame; anything written later sits behind that point.
            if (bus.flush) begin
                r_pend     <= 1'b1;
                r_pad_left <= w_occ + OCC_W'(w_wr_ok) - OCC_W'(w_rd_en);
            end else if (w_rd_en && r_pend && (r_pad_left != '0)) begin
                r_pad_left <= r_pad_left - OCC_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (r_pend) begin
                        if ((r_pad_left >= OCC_W'(BURST_WORDS)) && bus.room) begin
                            r_state <= SEND;
                        end else if ((r_pad_left == '0) && (r_cnt[BEAT_W-1:0] == '0)) begin
                            r_state <= DONE;
                        end else if (bus.room) begin
                            r_state <= PAD;
                        end
                    end else if ((w_occ >= OCC_W'(BURST_WORDS)) && bus.room) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    r_we   <= 1'b1;
                    r_di   <= w_rd_data;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_beat <= r_beat + BEAT_W'(1);
                    if (r_beat == '1) begin
                        r_state <= IDLE;
                    end
                end
                PAD: begin
                    if (w_emit) begin
                        r_we  <= 1'b1;
                        r_di  <= (r_pad_left != '0) ? w_rd_data : {PAD_BYTE, PAD_BYTE};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if ((r_pad_left <= OCC_W'(1)) && (r_cnt[BEAT_W-1:0] == '1)) begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_pend  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.we         = r_we;
    assign bus.di         = r_di;
    assign bus.frame_done = r_done;
    assign bus.overflow   = w_overflow;
    assign bus.word_cnt   = r_cnt;
    assign bus.busy       = (w_occ != '0) | r_pend | (r_state != IDLE) | r_held_vld;

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_burst_packer
// Description : Self-checking bench for dma_burst_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_burst_packer;

    localparam int         CNT_W    = 24;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    logic clk  = 1'b0;
    logic xrst = 1'b0;
    logic en   = 1'b0;

    dma_burst_packer_if #(.CNT_W(CNT_W)) bus ();

    dma_burst_packer #(.PAD_BYTE(PAD_BYTE), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .xrst (xrst),
        .en   (en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] q[$];
    logic [15:0] exp_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.we) q.push_back(bus.di);
        if (bus.frame_done) done_cnt++;
    end

    typedef struct {
        int               nbytes;
        logic [7:0]       b0;
        bit               flush;
        bit               fl_last;
        int               exp_words;
        logic [15:0]      exp_first;
        logic [15:0]      exp_last;
        logic [CNT_W-1:0] exp_wc;
        int               exp_done;
        int               chk_idx;
        logic [15:0]      chk_val;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_en();
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
    endtask

    task automatic stream(input int n, input logic [7:0] b0, input bit fl_last);
        for (int i = 0; i < n; i++) begin
            bus.din   = b0 + 8'(i);
            bus.dv    = 1'b1;
            bus.flush = fl_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        bus.dv    = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        if (k == budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout busy=%0b required 0", name, bus.busy);
        end
        repeat (3) @(negedge clk);
    endtask

    // Expected word stream built from the byte sequence alone.
    task automatic build_exp(input int n, input logic [7:0] b0, input bit fl);
        logic [7:0] lo;
        logic [7:0] hi;
        int full;
        exp_q.delete();
        for (int i = 0; i < n / 2; i++) begin
            lo = b0 + 8'(2 * i);
            hi = b0 + 8'(2 * i + 1);
            exp_q.push_back({hi, lo});
        end
        if (fl) begin
            if (n % 2 == 1) begin
                lo = b0 + 8'(n - 1);
                exp_q.push_back({PAD_BYTE, lo});
            end
            while (exp_q.size() % 16 != 0) exp_q.push_back({PAD_BYTE, PAD_BYTE});
        end else begin
            full = (exp_q.size() / 16) * 16;
            while (exp_q.size() > full) void'(exp_q.pop_back());
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int base;
        int dbase;
        int got;
        clear_en();
        base  = q.size();
        dbase = done_cnt;
        bus.room = 1'b1;
        stream(v.nbytes, v.b0, v.flush && v.fl_last);
        if (v.flush && !v.fl_last) begin
            bus.flush = 1'b1;
            @(posedge clk);
            #1 bus.flush = 1'b0;
        end
        wait_idle(400, $sformatf("v%0d_idle", k));
        got = q.size() - base;
        check($sformatf("v%0d_words", k), got, v.exp_words);
        if (v.exp_words > 0 && got > 0) begin
            check($sformatf("v%0d_first", k), q[base], v.exp_first);
            check($sformatf("v%0d_last", k), q[q.size() - 1], v.exp_last);
        end
        if (v.chk_idx >= 0 && got > v.chk_idx)
            check($sformatf("v%0d_word%0d", k, v.chk_idx), q[base + v.chk_idx], v.chk_val);
        check($sformatf("v%0d_word_cnt", k), bus.word_cnt, v.exp_wc);
        check($sformatf("v%0d_frame_done", k), done_cnt - dbase, v.exp_done);
        build_exp(v.nbytes, v.b0, v.flush);
        if (got == exp_q.size()) begin
            for (int i = 0; i < got; i++)
                check($sformatf("v%0d_stream%0d", k, i), q[base + i], exp_q[i]);
        end
    endtask

    initial begin
        int base;
        int n;
        bus.din   = '0;
        bus.dv    = 1'b0;
        bus.flush = 1'b0;
        bus.room  = 1'b0;

        //            n   b0     fl  last words first     last      wc  done idx val
        vecs[0] = '{32, 8'h00, 0, 0, 16, 16'h0100, 16'h1F1E, 16, 0, -1, 16'h0};
        vecs[1] = '{35, 8'h00, 1, 0, 32, 16'h0100, 16'h0000, 0,  1, 17, 16'h0022};
        vecs[2] = '{3,  8'hA0, 1, 0, 16, 16'hA1A0, 16'h0000, 0,  1, 1,  16'h00A2};
        vecs[3] = '{0,  8'h00, 1, 0, 0,  16'h0000, 16'h0000, 0,  1, -1, 16'h0};
        vecs[4] = '{48, 8'h10, 1, 0, 32, 16'h1110, 16'h0000, 0,  1, 23, 16'h3F3E};
        vecs[5] = '{64, 8'h00, 1, 0, 32, 16'h0100, 16'h3F3E, 0,  1, 16, 16'h2120};
        vecs[6] = '{33, 8'h80, 1, 1, 32, 16'h8180, 16'h0000, 0,  1, 16, 16'h00A0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_we", bus.we, 0);
        check("rst_busy", bus.busy, 0);
        xrst = 1'b1;
        en   = 1'b1;
        @(posedge clk);
        #1;
        check("rst_di", bus.di, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_word_cnt", bus.word_cnt, 0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Overflow with the downstream blocked, then drain.
        clear_en();
        base = q.size();
        bus.room = 1'b0;
        stream(64, 8'h00, 1'b0);
        @(negedge clk);
        check("ovf_pre", bus.overflow, 0);
        stream(6, 8'h40, 1'b0);
        @(negedge clk);
        check("ovf_set", bus.overflow, 1);
        check("ovf_no_we", q.size() - base, 0);
        bus.room = 1'b1;
        wait_idle(200, "ovf_idle");
        check("ovf_words", q.size() - base, 32);
        if (q.size() - base == 32) begin
            check("ovf_first", q[base], 16'h0100);
            check("ovf_last", q[base + 31], 16'h3F3E);
        end
        check("ovf_word_cnt", bus.word_cnt, 32);
        check("ovf_sticky", bus.overflow, 1);

        // Drop en at the fifth word of a burst.
        stream(32, 8'h60, 1'b0);
        n = 0;
        for (int k = 0; k < 100 && n < 5; k++) begin
            @(negedge clk);
            if (bus.we) n++;
        end
        check("en_reach5", n, 5);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_we", bus.we, 0);
        check("en_busy", bus.busy, 0);
        check("en_overflow", bus.overflow, 0);
        check("en_word_cnt", bus.word_cnt, 0);
        en = 1'b1;
        base = q.size();
        stream(32, 8'h40, 1'b0);
        wait_idle(200, "en_idle");
        check("en_words", q.size() - base, 16);
        if (q.size() - base == 16) begin
            check("en_first", q[base], 16'h4140);
            check("en_last", q[base + 15], 16'h5F5E);
        end

        // Asynchronous reset in the middle of a burst.
        stream(32, 8'h00, 1'b0);
        n = 0;
        for (int k = 0; k < 100 && n == 0; k++) begin
            @(negedge clk);
            if (bus.we) n++;
        end
        check("arst_burst_seen", n, 1);
        repeat (2) @(posedge clk);
        #3 xrst = 1'b0;
        #1;
        check("arst_we", bus.we, 0);
        check("arst_di", bus.di, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_word_cnt", bus.word_cnt, 0);
        @(posedge clk);
        #1 xrst = 1'b1;
        base = q.size();
        repeat (5) @(negedge clk);
        check("arst_quiet", q.size() - base, 0);
        check("arst_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
